// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions for the instruction-memory loader and
// the assembler benches.
package mips_pkg;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;
  localparam logic [1:0] FMT_BAD = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccept = 3'd1,
    StWrite  = 3'd2,
    StRead   = 3'd3,
    StCheck  = 3'd4,
    StDone   = 3'd5
  } loader_state_e;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;

  localparam int unsigned OPC_MSB    = 31;
  localparam int unsigned OPC_LSB    = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer from separate MIPS fields to a 32-bit instruction word.
// Illegal formats produce a NOP and raise o_illegal.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [1:0]          i_fmt,
  input  logic [OPC_W-1:0]    i_opcode,
  input  logic [REG_W-1:0]    i_rs,
  input  logic [REG_W-1:0]    i_rt,
  input  logic [REG_W-1:0]    i_rd,
  input  logic [SHAMT_W-1:0]  i_shamt,
  input  logic [FUNCT_W-1:0]  i_funct,
  input  logic [IMM_W-1:0]    i_imm,
  input  logic [TARGET_W-1:0] i_target,
  output logic [31:0]         o_word,
  output logic                o_illegal
);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    unique case (i_fmt)
      FMT_R: begin
        o_word[OPC_MSB:OPC_LSB]     = i_opcode;
        o_word[RS_MSB:RS_LSB]       = i_rs;
        o_word[RT_MSB:RT_LSB]       = i_rt;
        o_word[RD_MSB:RD_LSB]       = i_rd;
        o_word[SHAMT_MSB:SHAMT_LSB] = i_shamt;
        o_word[FUNCT_MSB:FUNCT_LSB] = i_funct;
      end
      FMT_I: begin
        o_word[OPC_MSB:OPC_LSB] = i_opcode;
        o_word[RS_MSB:RS_LSB]   = i_rs;
        o_word[RT_MSB:RT_LSB]   = i_rt;
        o_word[IMM_MSB:IMM_LSB] = i_imm;
      end
      FMT_J: begin
        o_word[OPC_MSB:OPC_LSB]       = i_opcode;
        o_word[TARGET_MSB:TARGET_LSB] = i_target;
      end
      FMT_BAD: begin
        o_illegal = 1'b1;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads field-encoded instructions into consecutive instruction-memory words,
// optionally reading each one back and flagging the first mismatching address.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned VERIFY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  r_reg1,
  input  logic [4:0]  r_reg2,
  input  logic [4:0]  w_reg,
  input  logic [4:0]  shift,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loader_state_e r_state;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_rem;
  logic [31:0]   r_word;

  logic [31:0]   w_enc_word;
  logic          w_enc_illegal;
  logic [AW-1:0] w_base_mod;
  logic [AW-1:0] w_addr_inc;
  logic          w_last;

  instr_encoder u_encoder (
    .i_fmt     (fmt),
    .i_opcode  (opcode),
    .i_rs      (r_reg1),
    .i_rt      (r_reg2),
    .i_rd      (w_reg),
    .i_shamt   (shift),
    .i_funct   (funct),
    .i_imm     (imm),
    .i_target  (target),
    .o_word    (w_enc_word),
    .o_illegal (w_enc_illegal)
  );

  assign w_base_mod = AW'(base_addr % DEPTH);
  assign w_addr_inc = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
  assign w_last     = (r_rem == 16'd1);

  // Outputs are registered: each transition sets the output values of the state it enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_rem     <= '0;
      r_word    <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_addr   <= w_base_mod;
            r_rem    <= count;
            err      <= 1'b0;
            err_addr <= '0;
            busy     <= 1'b1;
            if (count == 16'd0) begin
              r_state <= StDone;
              done    <= 1'b1;
            end else begin
              r_state  <= StAccept;
              in_ready <= 1'b1;
            end
          end
        end
        StAccept: begin
          if (in_valid) begin
            r_word    <= w_enc_word;
            r_state   <= StWrite;
            mem_we    <= 1'b1;
            mem_addr  <= 32'(r_addr);
            mem_wdata <= w_enc_word;
            if (w_enc_illegal && !err) begin
              err      <= 1'b1;
              err_addr <= 32'(r_addr);
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        StWrite: begin
          if (VERIFY != 0) begin
            r_state  <= StRead;
            mem_re   <= 1'b1;
            mem_addr <= 32'(r_addr);
          end else begin
            r_addr <= w_addr_inc;
            r_rem  <= r_rem - 16'd1;
            if (w_last) begin
              r_state <= StDone;
              done    <= 1'b1;
            end else begin
              r_state  <= StAccept;
              in_ready <= 1'b1;
            end
          end
        end
        StRead: begin
          r_state <= StCheck;
        end
        StCheck: begin
          // Only the first mismatch of a session is recorded.
          if ((mem_rdata != r_word) && !err) begin
            err      <= 1'b1;
            err_addr <= 32'(r_addr);
          end
          r_addr <= w_addr_inc;
          r_rem  <= r_rem - 16'd1;
          if (w_last) begin
            r_state <= StDone;
            done    <= 1'b1;
          end else begin
            r_state  <= StAccept;
            in_ready <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer-side counterpart of the instruction memory's decode path: takes instructions as separate fields (opcode, r_reg1, r_reg2, w_reg, shift, funct, imm, target), packs them into 32-bit MIPS words, and writes them to consecutive instruction-memory word addresses.
- Sits between the testbench or boot source and the instruction memory write port.
- Optional read-back verify checks every word that was written.

Parameters:
- DEPTH, 32, number of instruction-memory words; addresses wrap modulo DEPTH.
- VERIFY, 1, 1 = read back and compare each word after writing; 0 = skip read-back.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load session; ignored unless the FSM is in IDLE.
- base_addr  in  32  first word address, latched on start.
- count  in  16  number of instructions, latched on start.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  loader can accept fields.
- fmt  in  2  instruction format: 00 R-type, 01 I-type, 10 J-type, 11 illegal.
- opcode  in  6  instruction opcode.
- r_reg1  in  5  rs field.
- r_reg2  in  5  rt field.
- w_reg  in  5  rd field.
- shift  in  5  shamt field.
- funct  in  6  funct field.
- imm  in  16  I-type immediate.
- target  in  26  J-type target.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  32  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; synchronous read, valid the cycle after mem_re.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the session ends.
- err  out  1  sticky error flag; cleared on start or reset.
- err_addr  out  32  address of the first error.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-session aborts immediately; no further write is issued after the reset edge.
- Encoding, combinational from the inputs, registered on accept:
  - R-type: {opcode, r_reg1, r_reg2, w_reg, shift, funct}.
  - I-type: {opcode, r_reg1, r_reg2, imm}.
  - J-type: {opcode, target}.
  - Illegal (fmt 11): word 32'h0000_0000 (NOP) is written, and err is set if not already set.
- FSM states: IDLE, ACCEPT, WRITE, READ, CHECK, DONE.
  - IDLE: on start, latch addr = base_addr mod DEPTH and rem = count, and clear err and err_addr. Go to ACCEPT, or to DONE if count == 0.
  - ACCEPT: in_ready=1. On in_valid & in_ready, register the encoded word and go to WRITE. in_valid=0 stalls here indefinitely.
  - WRITE: for exactly one cycle, mem_we=1, mem_addr=addr, mem_wdata=word. Next state is READ if VERIFY=1, else the advance step.
  - READ: mem_re=1, mem_addr=addr for one cycle; next state is CHECK.
  - CHECK: compare mem_rdata with the registered word. On mismatch with err=0, set err=1 and err_addr=addr; later mismatches do not overwrite err_addr. Then advance.
  - Advance: addr = (addr+1) mod DEPTH and rem = rem-1. If the new rem == 0, go to DONE; otherwise go to ACCEPT.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: with VERIFY=1, one instruction takes 4 cycles from the accepting edge to the next in_ready (WRITE, READ, CHECK, ACCEPT); with VERIFY=0 it takes 2.
- in_ready is asserted only in ACCEPT, so at most one instruction is in flight.
- Address wrap: base_addr ≥ DEPTH is reduced modulo DEPTH. Writing past DEPTH-1 wraps to 0 silently, with no error.
- A start pulse while busy=1 is ignored, with no effect on any state.
- mem_we and mem_re are never asserted in the same cycle.
- mem_addr holds its last value when no enable is asserted; mem_wdata is 0 outside WRITE.

Decomposition:
- Shared package mips_pkg holds:
  - fmt constants FMT_R, FMT_I, FMT_J, FMT_BAD;
  - FSM state encoding;
  - instruction field widths and bit positions (OPC_MSB=31, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNCT 5:0, IMM 15:0, TARGET 25:0).
- One sub-module, instr_encoder: purely combinational field packer that outputs the 32-bit word and an illegal flag. It is reused by future assembler benches.

Test Plan:
- R-type: start with base_addr=1, count=1; send fmt=00, opcode=0, r_reg1=1, r_reg2=2, w_reg=3, shift=0, funct=6'h20 -> mem_we at addr 1 with wdata=32'h0022_1820, then done pulses and err=0.
- Three back-to-back: count=3, base_addr=1 with I-type (opcode 6'h08, rs=1, rt=2, imm=16'h0005), J-type (opcode 6'h02, target=26'h10) and an R-type -> writes 32'h2022_0005 at addr 1, 32'h0800_0010 at addr 2, then the R word at addr 3; in_ready gap of 3 cycles between accepts.
- Wrap: DEPTH=32, base_addr=31, count=2 -> writes at addr 31 then addr 0; err=0.
- Verify mismatch: the memory model corrupts the read of addr 5 in a 4-word load from base 4 -> err=1 and err_addr=5 after CHECK; a later injected mismatch leaves err_addr=5.
- Illegal fmt=11 -> 32'h0 written, err=1; a start during busy is ignored; count=0 gives done one cycle after start.
- Reset: rst_n driven low in the cycle after an accept -> no mem_we at the next edge; all outputs 0; FSM in IDLE; a new start works normally.
